// File: rtl/pmi_ram_dq_arb.sv
// Round-robin arbiter sharing one single-port pmi_ram_dq between requesters A and B.
// Grant is same-cycle combinational; reads return RD_LATENCY cycles later; no backpressure on read return.
module pmi_ram_dq_arb #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 18,
  parameter int RD_LATENCY = 2
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  ReqA,
  input  logic                  WeA,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] DataA,
  output logic                  GntA,
  output logic                  RdValidA,
  output logic [DATA_WIDTH-1:0] RdDataA,
  input  logic                  ReqB,
  input  logic                  WeB,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic                  GntB,
  output logic                  RdValidB,
  output logic [DATA_WIDTH-1:0] RdDataB,
  output logic [ADDR_WIDTH-1:0] RamAddress,
  output logic [DATA_WIDTH-1:0] RamData,
  output logic                  RamWE,
  output logic                  RamClockEn,
  output logic                  RamReset,
  input  logic [DATA_WIDTH-1:0] RamQ
);

  logic                  last_gnt_b;
  logic [RD_LATENCY-1:0] tag_vld;
  logic [RD_LATENCY-1:0] tag_own;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rd_a_q;
  logic [DATA_WIDTH-1:0] rd_b_q;
  logic                  rd_issue;
  logic                  ret_vld;
  logic                  ret_own;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    GntA = Reset_n & ReqA & (~ReqB | last_gnt_b);
    GntB = Reset_n & ReqB & ~GntA;
  end

  always_comb begin
    RamAddress = addr_q;
    RamData    = data_q;
    RamWE      = 1'b0;
    if (GntA) begin
      RamAddress = AddrA;
      RamData    = DataA;
      RamWE      = WeA;
    end else if (GntB) begin
      RamAddress = AddrB;
      RamData    = DataB;
      RamWE      = WeB;
    end
  end

  assign RamClockEn = Reset_n;
  assign RamReset   = ~Reset_n;
  assign rd_issue   = (GntA & ~WeA) | (GntB & ~WeB);

  assign ret_vld  = tag_vld[RD_LATENCY-1];
  assign ret_own  = tag_own[RD_LATENCY-1];
  assign RdValidA = ret_vld & ~ret_own;
  assign RdValidB = ret_vld & ret_own;
  assign RdDataA  = RdValidA ? RamQ : rd_a_q;
  assign RdDataB  = RdValidB ? RamQ : rd_b_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_gnt_b <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      tag_vld    <= '0;
      tag_own    <= '0;
    end else begin
      if (GntA) begin
        last_gnt_b <= 1'b0;
      end else if (GntB) begin
        last_gnt_b <= 1'b1;
      end
      addr_q     <= RamAddress;
      data_q     <= RamData;
      rd_a_q     <= RdDataA;
      rd_b_q     <= RdDataB;
      // Tag pipeline depth equals RAM read latency so the last stage lines up with Q.
      tag_vld[0] <= rd_issue;
      tag_own[0] <= GntB;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

endmodule
